// File: rtl/sm_msg_scheduler.sv
// sm_msg_scheduler: buffers message-event requests in a small FIFO and hands
// them one at a time to the XBee UART transmitter. Enforces a quiet gap between
// messages and a watchdog on each send. Reports drops, malformed requests and
// aborted sends.
module sm_msg_scheduler #(
  parameter int DEPTH          = 4,
  parameter int GAP_CYCLES     = 5000,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic                   clk_50M,
  input  logic                   rst,
  input  logic                   evt_valid,
  input  logic [1:0]             evt_msg_type,
  input  logic [1:0]             evt_field,
  input  logic [1:0]             evt_node_si,
  input  logic [1:0]             evt_color,
  output logic                   evt_ready,
  input  logic                   tx_complete,
  output logic                   tx_start,
  output logic [1:0]             msg_type,
  output logic [1:0]             field,
  output logic [1:0]             node_si,
  output logic [1:0]             color,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   invalid,
  output logic                   timeout_err,
  output logic [7:0]             sent_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      entry_q, entry_d;
  logic            tx_start_q, tx_start_d;
  logic            busy_q, busy_d;
  logic            overflow_q, overflow_d;
  logic            invalid_q, invalid_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      sent_q, sent_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic            well_formed;
  logic            pop;
  logic            push;
  logic            ready;
  logic [7:0]      new_entry;

  // Request qualification: a pop frees a slot in the same cycle, so a full FIFO still accepts then
  always_comb begin
    well_formed = (evt_msg_type != 2'd0) && (evt_node_si != 2'd0) && (evt_color != 2'd0);
    pop         = (state_q == S_IDLE) && (count_q != '0);
    ready       = (count_q < DEPTH_C) || pop;
    push        = evt_valid && well_formed && ready;
    new_entry   = {evt_msg_type, evt_field, evt_node_si, evt_color};
  end

  // FIFO storage, pointers, occupancy and the two request-side sticky flags
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    invalid_d  = invalid_q;
    if (evt_valid && !well_formed) begin
      invalid_d = 1'b1;
    end else if (evt_valid && !ready) begin
      overflow_d = 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer: pop into the field registers, hold tx_start until done or watchdog, then a quiet gap
  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    sent_d    = sent_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          entry_d = mem_q[rd_ptr_q];
          timer_d = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if ((timer_q != '0) && tx_complete) begin
          sent_d  = sent_q + 8'd1;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (timer_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          gap_d     = '0;
          state_d   = S_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    tx_start_d = (state_d == S_SEND);
    busy_d     = (state_d != S_IDLE);
  end

  // All state registers, cleared together by synchronous reset
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      entry_q    <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
      timeout_q  <= 1'b0;
      sent_q     <= '0;
      timer_q    <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      entry_q    <= entry_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      invalid_q  <= invalid_d;
      timeout_q  <= timeout_d;
      sent_q     <= sent_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
    end
  end

  assign evt_ready   = ready;
  assign tx_start    = tx_start_q;
  assign msg_type    = entry_q[7:6];
  assign field       = entry_q[5:4];
  assign node_si     = entry_q[3:2];
  assign color       = entry_q[1:0];
  assign busy        = busy_q;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign invalid     = invalid_q;
  assign timeout_err = timeout_q;
  assign sent_count  = sent_q;

endmodule

// File: tb/tb_sm_msg_scheduler.sv
// tb_sm_msg_scheduler: drives directed and random requests into the scheduler,
// emulates the UART transmitter's completion flag, and compares every output
// against a queue-based reference model plus an in-order message scoreboard.
module tb_sm_msg_scheduler;

  localparam int DEPTH = 4;
  localparam int GAP   = 50;
  localparam int TMO   = 1000;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam int PH_IDLE = 0;
  localparam int PH_SEND = 1;
  localparam int PH_GAP  = 2;

  logic          clk_50M = 1'b0;
  logic          rst = 1'b0;
  logic          evt_valid = 1'b0;
  logic [1:0]    evt_msg_type = 2'd0;
  logic [1:0]    evt_field = 2'd0;
  logic [1:0]    evt_node_si = 2'd0;
  logic [1:0]    evt_color = 2'd0;
  logic          evt_ready;
  logic          tx_complete = 1'b0;
  logic          tx_start;
  logic [1:0]    msg_type, field, node_si, color;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow, invalid, timeout_err;
  logic [7:0]    sent_count;

  int checks = 0;
  int errors = 0;

  sm_msg_scheduler #(
    .DEPTH(DEPTH),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_50M(clk_50M),
    .rst(rst),
    .evt_valid(evt_valid),
    .evt_msg_type(evt_msg_type),
    .evt_field(evt_field),
    .evt_node_si(evt_node_si),
    .evt_color(evt_color),
    .evt_ready(evt_ready),
    .tx_complete(tx_complete),
    .tx_start(tx_start),
    .msg_type(msg_type),
    .field(field),
    .node_si(node_si),
    .color(color),
    .busy(busy),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .invalid(invalid),
    .timeout_err(timeout_err),
    .sent_count(sent_count)
  );

  always #10 clk_50M = ~clk_50M;

  // Single comparison point: every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a plain queue plus a phase and cycle counts derived from the message rules
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  int         m_phase = PH_IDLE;
  int         m_send_n = 0;
  int         m_gap_n = 0;
  logic [7:0] m_cur = 8'd0;
  int         m_sent = 0;
  bit         m_ovf = 0, m_inv = 0, m_tmo = 0;

  always @(posedge clk_50M) begin : ref_model
    bit         pop_now;
    bit         ready_now;
    bit         accept;
    logic [7:0] req;
    int         n;
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_phase = PH_IDLE;
      m_send_n = 0;
      m_gap_n = 0;
      m_cur = 8'd0;
      m_sent = 0;
      m_ovf = 0;
      m_inv = 0;
      m_tmo = 0;
    end else begin
      pop_now   = (m_phase == PH_IDLE) && (m_q.size() > 0);
      ready_now = (m_q.size() < DEPTH) || pop_now;
      accept    = 0;
      req       = {evt_msg_type, evt_field, evt_node_si, evt_color};
      if (evt_valid) begin
        if (evt_msg_type == 0 || evt_node_si == 0 || evt_color == 0) m_inv = 1;
        else if (!ready_now) m_ovf = 1;
        else accept = 1;
      end
      case (m_phase)
        PH_IDLE: if (pop_now) begin
          m_cur = m_q.pop_front();
          m_send_n = 0;
          m_phase = PH_SEND;
        end
        PH_SEND: begin
          n = m_send_n + 1;
          if (n >= 2 && tx_complete) begin
            m_sent = (m_sent + 1) % 256;
            m_gap_n = 0;
            m_phase = PH_GAP;
          end else if (n == TMO) begin
            m_tmo = 1;
            m_gap_n = 0;
            m_phase = PH_GAP;
          end else begin
            m_send_n = n;
          end
        end
        default: begin
          m_gap_n++;
          if (m_gap_n == GAP) m_phase = PH_IDLE;
        end
      endcase
      if (accept) begin
        m_q.push_back(req);
        exp_q.push_back(req);
      end
    end
  end

  // Monitor: full status compare every cycle, and in-order scoreboard pop on each new message
  bit mon_en = 0;
  bit prev_tx = 0;

  always @(negedge clk_50M) begin : monitor
    logic [31:0] act, exp;
    logic [7:0]  head;
    if (mon_en) begin
      act = {7'd0, tx_start, busy, evt_ready, overflow, invalid, timeout_err,
             CW'(fifo_count), sent_count, msg_type, field, node_si, color};
      exp = {7'd0, (m_phase == PH_SEND), (m_phase != PH_IDLE),
             ((m_q.size() < DEPTH) || (m_phase == PH_IDLE && m_q.size() > 0)),
             m_ovf, m_inv, m_tmo, CW'(m_q.size()), 8'(m_sent), m_cur};
      checkOutput("status", act, exp);
      if (tx_start === 1'b1 && !prev_tx) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_unexpected_msg", {msg_type, field, node_si, color}, 32'hFFFF_FFFF);
        end else begin
          head = exp_q.pop_front();
          checkOutput("sb_msg_order", {msg_type, field, node_si, color}, head);
        end
      end
      prev_tx = (tx_start === 1'b1);
    end
  end

  // Transmitter emulator: completion flag stays high (stale) after a message until the next starts
  int  fixed_lat = 0;
  bit  hang = 0;
  bit  stale = 0;
  int  tx_k = 0;
  int  tx_lat = 2;

  always @(negedge clk_50M) begin : xmit
    if (tx_start === 1'b1) begin
      tx_k++;
      if (tx_k == 1) begin
        tx_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(2, 30));
        tx_complete = hang ? 1'b0 : stale;
      end else if (hang) begin
        tx_complete = 1'b0;
      end else if (tx_k == tx_lat) begin
        tx_complete = 1'b1;
        stale = 1;
      end else begin
        tx_complete = 1'b0;
      end
    end else begin
      tx_k = 0;
      tx_complete = hang ? 1'b0 : stale;
    end
  end

  task automatic applyStimulus(input logic [1:0] t, input logic [1:0] f, input logic [1:0] n, input logic [1:0] c);
    @(negedge clk_50M);
    evt_valid    = 1'b1;
    evt_msg_type = t;
    evt_field    = f;
    evt_node_si  = n;
    evt_color    = c;
  endtask

  task automatic stopStimulus();
    @(negedge clk_50M);
    evt_valid    = 1'b0;
    evt_msg_type = 2'd0;
    evt_field    = 2'd0;
    evt_node_si  = 2'd0;
    evt_color    = 2'd0;
  endtask

  // Bounded wait for tx_start to reach a level; returns the number of cycles waited
  task automatic waitTx(input logic lvl, input int budget, input string name, output int cycles);
    cycles = 0;
    while (tx_start !== lvl && cycles < budget) begin
      @(negedge clk_50M);
      cycles++;
    end
    checkOutput(name, tx_start, lvl);
  endtask

  task automatic waitIdle(input int budget, input string name);
    int i;
    i = 0;
    while ((busy !== 1'b0 || fifo_count !== '0) && i < budget) begin
      @(negedge clk_50M);
      i++;
    end
    checkOutput(name, {busy, fifo_count}, 0);
  endtask

  initial begin : watchdog
    #(60000 * 20);
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : main
    int         len;
    int         sent_before;
    int         i;
    logic [1:0] t, f, n, c;

    // Reset and reset-state checks
    rst = 1'b1;
    repeat (3) @(negedge clk_50M);
    rst = 1'b0;
    checkOutput("rst_tx_start", tx_start, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_flags", {overflow, invalid, timeout_err}, 0);
    checkOutput("rst_sent_count", sent_count, 0);
    checkOutput("rst_fields", {msg_type, field, node_si, color}, 0);
    mon_en = 1;

    // Single request, stale completion in first SEND cycle, completion on cycle 100
    stale = 1;
    fixed_lat = 100;
    applyStimulus(2'd1, 2'd3, 2'd1, 2'd2);
    stopStimulus();
    checkOutput("single_lat1_tx", tx_start, 0);
    checkOutput("single_lat1_cnt", fifo_count, 1);
    @(negedge clk_50M);
    checkOutput("single_lat2_tx", tx_start, 1);
    checkOutput("single_fields", {msg_type, field, node_si, color}, 8'b01_11_01_10);
    waitTx(1'b0, 300, "single_done", len);
    checkOutput("single_send_len", len, 100);
    checkOutput("single_sent", sent_count, 1);
    checkOutput("single_busy_gap_start", busy, 1);
    repeat (GAP - 1) @(negedge clk_50M);
    checkOutput("single_busy_gap_end", busy, 1);
    @(negedge clk_50M);
    checkOutput("single_idle_after_gap", busy, 0);

    // Burst of 6 while the sequencer is mid-send: 4 stored, 2 dropped
    fixed_lat = 300;
    applyStimulus(2'd2, 2'd0, 2'd3, 2'd3);
    stopStimulus();
    @(negedge clk_50M);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'(1 + (k % 3)), 2'(k % 4), 2'(1 + ((k + 1) % 3)), 2'(1 + ((k + 2) % 3)));
    end
    stopStimulus();
    checkOutput("burst_count", fifo_count, 4);
    checkOutput("burst_ready", evt_ready, 0);
    checkOutput("burst_overflow", overflow, 1);
    fixed_lat = 0;
    waitIdle(3000, "burst_drain");

    // Malformed requests are rejected and never stored
    applyStimulus(2'd1, 2'd1, 2'd0, 2'd1);
    applyStimulus(2'd2, 2'd2, 2'd2, 2'd0);
    applyStimulus(2'd0, 2'd3, 2'd3, 2'd3);
    stopStimulus();
    checkOutput("invalid_flag", invalid, 1);
    repeat (4) @(negedge clk_50M);
    checkOutput("invalid_count", fifo_count, 0);
    checkOutput("invalid_no_tx", tx_start, 0);

    // Watchdog: transmitter never completes, next message follows after the gap
    hang = 1;
    sent_before = sent_count;
    applyStimulus(2'd3, 2'd1, 2'd2, 2'd1);
    applyStimulus(2'd1, 2'd2, 2'd3, 2'd3);
    stopStimulus();
    waitTx(1'b1, 10, "tmo_start", len);
    waitTx(1'b0, TMO + 50, "tmo_abort", len);
    checkOutput("tmo_send_len", len, TMO);
    checkOutput("tmo_flag", timeout_err, 1);
    checkOutput("tmo_sent_unchanged", sent_count, sent_before);
    hang = 0;
    waitTx(1'b1, GAP + 20, "tmo_next_start", len);
    checkOutput("tmo_gap_len", len, GAP + 1);
    waitIdle(500, "tmo_drain");

    // Full FIFO with an IDLE pop and a push in the same cycle
    fixed_lat = 200;
    applyStimulus(2'd1, 2'd0, 2'd1, 2'd1);
    for (int k = 0; k < 4; k++) applyStimulus(2'd2, 2'(k), 2'd2, 2'(1 + (k % 3)));
    stopStimulus();
    i = 0;
    while (!(m_phase == PH_IDLE && m_q.size() == DEPTH) && i < 600) begin
      @(negedge clk_50M);
      i++;
    end
    checkOutput("full_reach_idle", fifo_count, 4);
    evt_valid = 1'b1;
    evt_msg_type = 2'd3;
    evt_field = 2'd3;
    evt_node_si = 2'd3;
    evt_color = 2'd3;
    @(negedge clk_50M);
    evt_valid = 1'b0;
    checkOutput("full_pushpop_count", fifo_count, 4);
    checkOutput("full_pushpop_tx", tx_start, 1);
    fixed_lat = 0;

    // Random traffic: mostly well-formed requests, random transmitter latency
    for (int k = 0; k < 2500; k++) begin
      @(negedge clk_50M);
      if ($urandom_range(0, 99) < 35) begin
        t = 2'($urandom_range(1, 3));
        f = 2'($urandom_range(0, 3));
        n = 2'($urandom_range(1, 3));
        c = 2'($urandom_range(1, 3));
        case ($urandom_range(0, 19))
          0: t = 2'd0;
          1: n = 2'd0;
          2: c = 2'd0;
          default: ;
        endcase
        evt_valid = 1'b1;
        evt_msg_type = t;
        evt_field = f;
        evt_node_si = n;
        evt_color = c;
      end else begin
        evt_valid = 1'b0;
      end
    end
    stopStimulus();
    waitIdle(2000, "random_drain");
    checkOutput("random_sb_empty", exp_q.size(), 0);

    // Reset in the middle of a send with three entries queued
    fixed_lat = 300;
    for (int k = 0; k < 4; k++) applyStimulus(2'(1 + (k % 3)), 2'(k), 2'd1, 2'd2);
    stopStimulus();
    checkOutput("mid_rst_pre_tx", tx_start, 1);
    checkOutput("mid_rst_pre_count", fifo_count, 3);
    rst = 1'b1;
    @(negedge clk_50M);
    rst = 1'b0;
    checkOutput("mid_rst_tx", tx_start, 0);
    checkOutput("mid_rst_count", fifo_count, 0);
    checkOutput("mid_rst_flags", {overflow, invalid, timeout_err}, 0);
    checkOutput("mid_rst_sent", sent_count, 0);
    checkOutput("mid_rst_busy", busy, 0);
    repeat (400) @(negedge clk_50M);
    checkOutput("mid_rst_quiet_tx", tx_start, 0);
    checkOutput("mid_rst_quiet_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
